sraml_bridge: RTL and testbench
===============================

Name: sraml_bridge

Overview:
- Parametrised SRAM-to-SRAM-like bridge; next generation of the per-channel instruction/data bridges that sit between the mips core and the AXI-side SRAM-like interface.
- One instance per channel: fetch uses WRITE_EN=0, load/store uses WRITE_EN=1.
- Adds over the previous bridges:
  - parametrised address and data width;
  - 64-bit size encoding;
  - request-field latching;
  - a flush input that discards an in-flight response without breaking the SRAM-like handshake.
- Cooperates with the other channel through longest_stall, so a completed access is held until the whole pipeline advances.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; legal values 32 or 64.
- WRITE_EN, 1, 1 = read/write channel; 0 = read-only (wr tied 0, sram_wen ignored).
- READ_SIZE, 2, size code driven for reads (2 = 4 bytes, 3 = 8 bytes).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sram_en  in  1  core access request (level)
- sram_addr  in  ADDR_W  core byte address
- sram_wen  in  DATA_W/8  byte write enables; 0 = read
- sram_wdata  in  DATA_W  write data
- sram_rdata  out  DATA_W  read data returned to core
- stall  out  1  core must hold this access
- longest_stall  in  1  OR of all pipeline stall sources
- flush  in  1  pipeline flush (exception/eret); current access is dropped
- req  out  1  SRAM-like request
- wr  out  1  1 = write
- size  out  2  0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
- addr  out  ADDR_W  request address
- wdata  out  DATA_W  request write data
- addr_ok  in  1  request accepted
- data_ok  in  1  response/write complete
- rdata  in  DATA_W  response data

Behaviour:
- States: IDLE, REQ, DATA, DONE. At most one access outstanding.
- On reset:
  - state = IDLE, discard = 0, rbuf = 0;
  - req = 0, wr = 0, size = 0, addr = 0, wdata = 0, sram_rdata = 0;
  - stall = 0.
- Reset mid-access returns to IDLE immediately; any late data_ok is ignored.
- IDLE:
  - sram_en & ~flush → REQ.
  - On that edge, latch addr = sram_addr, wdata = sram_wdata, wr = WRITE_EN & |sram_wen, and size.
  - Size for reads = READ_SIZE.
- Size for writes (WRITE_EN=1):
  - one-hot byte lane → 0;
  - aligned 2-bit pair → 1;
  - aligned 4-bit group → 2;
  - all ones (DATA_W=64) → 3;
  - any other pattern → 2 (DATA_W=32) or 3 (DATA_W=64).
- REQ:
  - req = 1; addr, size, wr and wdata held stable.
  - addr_ok → DATA.
  - req is never withdrawn before addr_ok, even under flush.
- DATA:
  - req = 0.
  - data_ok → capture rbuf = rdata. Then:
    - discard set → clear discard, go to IDLE;
    - otherwise → DONE.
- DONE:
  - stall = 0; sram_rdata = rbuf.
  - ~longest_stall or flush → IDLE. Otherwise remain in DONE (other channel still stalling).
- stall = sram_en & ~flush & (state != DONE).
  - In REQ/DATA with discard set, stall = 0.
- flush:
  - in REQ or DATA, sets discard;
  - in IDLE, prevents the transition to REQ;
  - in DONE, returns to IDLE.
- data_ok outside DATA and addr_ok outside REQ are ignored.
- sram_rdata holds rbuf at all times, so it is stable throughout DONE.
- Minimum latency: addr_ok in the first REQ cycle and data_ok in the first DATA cycle give stall high for 3 cycles (IDLE, REQ, DATA); stall is low in the 4th cycle (DONE).
- A new access may start in the cycle after leaving DONE.

Decomposition:
- Package sraml_pkg holds:
  - state enum (IDLE/REQ/DATA/DONE);
  - size constants SZ_B/SZ_H/SZ_W/SZ_D;
  - function wen_to_size.
- One sub-module, sraml_size_enc: combinational sram_wen → size encoder, parametrised by DATA_W. It is reused by the planned cached bridge.

Test Plan:
- Read, DATA_W=32, addr=0xBFC00000, addr_ok and data_ok each 1 cycle late, rdata=0x3C1D0001 → req high 2 cycles; size=2, wr=0; stall high 5 cycles; then sram_rdata=0x3C1D0001.
- Write, sram_wen=4'b1100, addr=0x80000002, wdata=0xABCD0000 → size=1, wr=1, wdata=0xABCD0000 latched and held while sram_addr changes in REQ.
- Hold under longest_stall: data_ok arrives while longest_stall stays high 3 more cycles → state stays DONE, stall=0, sram_rdata stable; returns to IDLE in the cycle longest_stall drops.
- Flush in REQ before addr_ok → req held until addr_ok; data_ok=0xDEADBEEF is discarded; state IDLE, stall=0, no DONE entry.
- DATA_W=64, sram_wen=8'hFF → size=3; sram_wen=8'h0F → size=2; WRITE_EN=0 with sram_wen=8'hFF → wr=0, size=READ_SIZE.
- rst asserted in DATA → next cycle IDLE, all outputs 0; subsequent data_ok ignored; next sram_en starts a clean REQ.

Source files
------------

// File: rtl/sraml_pkg.sv
// sraml_pkg: shared states, size codes and byte-enable to size mapping for the SRAM-like bridges
package sraml_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Byte enables are zero-extended to 8 lanes; irregular patterns widen to the full bus
    function automatic logic [1:0] wen_to_size(input logic [7:0] wen, input logic is64);
        logic onehot, pair, quad;
        onehot = (wen != 8'h00) && ((wen & (wen - 8'h01)) == 8'h00);
        pair   = wen inside {8'h03, 8'h0C, 8'h30, 8'hC0};
        quad   = wen inside {8'h0F, 8'hF0};
        return onehot ? SZ_B : pair ? SZ_H : quad ? SZ_W : is64 ? SZ_D : SZ_W;
    endfunction

endpackage

// File: rtl/sraml_size_enc.sv
// sraml_size_enc: combinational byte-enable to SRAM-like size encoder
module sraml_size_enc
    import sraml_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0] wen,
    output logic [1:0]          size
);

    assign size = wen_to_size(8'(wen), DATA_W == 64);

endmodule

// File: rtl/sraml_bridge.sv
// sraml_bridge: single-outstanding core SRAM to SRAM-like bridge with flush discard and pipeline hold
module sraml_bridge
    import sraml_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int WRITE_EN  = 1,
    parameter int READ_SIZE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sram_en,
    input  logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W/8-1:0] sram_wen,
    input  logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W-1:0]   sram_rdata,
    output logic                stall,
    input  logic                longest_stall,
    input  logic                flush,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata
);

    logic [1:0]        state;
    logic              discard;
    logic [DATA_W-1:0] rbuf;
    logic [1:0]        wsize;
    logic              is_wr;

    sraml_size_enc #(.DATA_W(DATA_W)) u_enc (.wen(sram_wen), .size(wsize));

    assign is_wr      = (WRITE_EN != 0) && (|sram_wen);
    assign req        = state == REQ;
    assign sram_rdata = rbuf;
    // A discarded access no longer holds the core; it only finishes the bus handshake
    assign stall      = sram_en & ~flush & (state != DONE) & ~(discard & (state == REQ | state == DATA));

    // Access FSM: request fields are latched on entry to REQ and held until the next access
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            discard <= 1'b0;
            rbuf    <= '0;
            wr      <= 1'b0;
            size    <= SZ_B;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            case (state)
                IDLE: if (sram_en && !flush) begin
                    state <= REQ;
                    addr  <= sram_addr;
                    wdata <= sram_wdata;
                    wr    <= is_wr;
                    size  <= is_wr ? wsize : 2'(READ_SIZE);
                end
                REQ: begin
                    if (flush) discard <= 1'b1;
                    if (addr_ok) state <= DATA;
                end
                DATA: if (data_ok) begin
                    rbuf    <= rdata;
                    discard <= 1'b0;
                    state   <= (discard || flush) ? IDLE : DONE;
                end else if (flush) begin
                    discard <= 1'b1;
                end
                DONE: if (!longest_stall || flush) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sraml_bridge.sv
// tb_sraml_bridge: directed checks of the bridge on 32-bit r/w, 64-bit r/w and 64-bit read-only channels
module tb_sraml_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en = 0, ls = 0, fl = 0, aok = 0, dok = 0;
    logic [31:0] saddr = 0, swdata = 0, rd = 0;
    logic [3:0]  wen = 0;
    logic [31:0] srdata, oaddr, owdata;
    logic        stall, req, wr;
    logic [1:0]  size;

    logic        en64 = 0;
    logic [7:0]  wen64 = 0;
    logic [63:0] a_rdata, a_wdata, b_rdata, b_wdata;
    logic [31:0] a_addr, b_addr;
    logic        a_stall, a_req, a_wr, b_stall, b_req, b_wr;
    logic [1:0]  a_size, b_size;

    int pass_n = 0;
    int total_n = 0;

    sraml_bridge #(.ADDR_W(32), .DATA_W(32), .WRITE_EN(1), .READ_SIZE(2)) u32 (
        .clk(clk), .rst(rst), .sram_en(en), .sram_addr(saddr), .sram_wen(wen),
        .sram_wdata(swdata), .sram_rdata(srdata), .stall(stall), .longest_stall(ls),
        .flush(fl), .req(req), .wr(wr), .size(size), .addr(oaddr), .wdata(owdata),
        .addr_ok(aok), .data_ok(dok), .rdata(rd)
    );

    sraml_bridge #(.ADDR_W(32), .DATA_W(64), .WRITE_EN(1), .READ_SIZE(3)) u64 (
        .clk(clk), .rst(rst), .sram_en(en64), .sram_addr(32'h0), .sram_wen(wen64),
        .sram_wdata(64'h0), .sram_rdata(a_rdata), .stall(a_stall), .longest_stall(1'b0),
        .flush(1'b0), .req(a_req), .wr(a_wr), .size(a_size), .addr(a_addr), .wdata(a_wdata),
        .addr_ok(1'b0), .data_ok(1'b0), .rdata(64'h0)
    );

    sraml_bridge #(.ADDR_W(32), .DATA_W(64), .WRITE_EN(0), .READ_SIZE(3)) u64r (
        .clk(clk), .rst(rst), .sram_en(en64), .sram_addr(32'h0), .sram_wen(wen64),
        .sram_wdata(64'h0), .sram_rdata(b_rdata), .stall(b_stall), .longest_stall(1'b0),
        .flush(1'b0), .req(b_req), .wr(b_wr), .size(b_size), .addr(b_addr), .wdata(b_wdata),
        .addr_ok(1'b0), .data_ok(1'b0), .rdata(64'h0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        rst = 0;
        #1;
        chk("rst_state", 64'(u32.state), 0);
        chk("rst_req", 64'(req), 0);
        chk("rst_wr", 64'(wr), 0);
        chk("rst_size", 64'(size), 0);
        chk("rst_addr", 64'(oaddr), 0);
        chk("rst_wdata", 64'(owdata), 0);
        chk("rst_rdata", 64'(srdata), 0);
        chk("rst_stall", 64'(stall), 0);

        // read with addr_ok and data_ok each one cycle late
        en = 1; saddr = 32'hBFC00000; wen = 0;
        #1;
        chk("rd_idle_stall", 64'(stall), 1);
        chk("rd_idle_req", 64'(req), 0);
        step();
        chk("rd_req1", 64'(req), 1);
        chk("rd_size", 64'(size), 2);
        chk("rd_wr", 64'(wr), 0);
        chk("rd_addr", 64'(oaddr), 64'hBFC00000);
        chk("rd_req1_stall", 64'(stall), 1);
        step();
        aok = 1;
        #1;
        chk("rd_req2", 64'(req), 1);
        chk("rd_req2_stall", 64'(stall), 1);
        step();
        aok = 0;
        #1;
        chk("rd_data1_req", 64'(req), 0);
        chk("rd_data1_stall", 64'(stall), 1);
        step();
        dok = 1; rd = 32'h3C1D0001;
        #1;
        chk("rd_data2_stall", 64'(stall), 1);
        step();
        dok = 0; rd = 0;
        #1;
        chk("rd_done_state", 64'(u32.state), 3);
        chk("rd_done_stall", 64'(stall), 0);
        chk("rd_done_rdata", 64'(srdata), 64'h3C1D0001);
        en = 0;
        step();
        chk("rd_back_idle", 64'(u32.state), 0);

        // halfword write, then hold in DONE under longest_stall
        en = 1; saddr = 32'h80000002; wen = 4'b1100; swdata = 32'hABCD0000; ls = 1;
        step();
        saddr = 32'h12345678; swdata = 32'h0; wen = 4'b0001;
        #1;
        chk("wr_size", 64'(size), 1);
        chk("wr_wr", 64'(wr), 1);
        chk("wr_addr_held", 64'(oaddr), 64'h80000002);
        chk("wr_wdata_held", 64'(owdata), 64'hABCD0000);
        aok = 1;
        step();
        aok = 0; dok = 1; rd = 32'h11223344;
        step();
        dok = 0; rd = 32'h99999999;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_state", 64'(u32.state), 3);
            chk("hold_stall", 64'(stall), 0);
            chk("hold_rdata", 64'(srdata), 64'h11223344);
            step();
        end
        ls = 0; en = 0;
        #1;
        chk("hold_last_state", 64'(u32.state), 3);
        step();
        chk("hold_release", 64'(u32.state), 0);

        // flush in REQ before addr_ok: handshake completes, response dropped
        en = 1; saddr = 32'h00000100; wen = 0;
        step();
        fl = 1;
        #1;
        chk("fl_req_held", 64'(req), 1);
        chk("fl_stall", 64'(stall), 0);
        step();
        fl = 0;
        #1;
        chk("fl_req_still", 64'(req), 1);
        chk("fl_discard_stall", 64'(stall), 0);
        aok = 1;
        step();
        aok = 0; dok = 1; rd = 32'hDEADBEEF;
        step();
        dok = 0; en = 0;
        #1;
        chk("fl_state_idle", 64'(u32.state), 0);
        chk("fl_idle_stall", 64'(stall), 0);
        step();
        chk("fl_no_done", 64'(u32.state), 0);

        // reset in DATA, late data_ok ignored, clean restart
        en = 1; saddr = 32'h00000200; wen = 4'hF; swdata = 32'h55;
        step();
        chk("rs_word_size", 64'(size), 2);
        aok = 1;
        step();
        aok = 0; rst = 1; en = 0;
        step();
        rst = 0;
        #1;
        chk("rs_state", 64'(u32.state), 0);
        chk("rs_req", 64'(req), 0);
        chk("rs_wr", 64'(wr), 0);
        chk("rs_size", 64'(size), 0);
        chk("rs_addr", 64'(oaddr), 0);
        chk("rs_wdata", 64'(owdata), 0);
        chk("rs_rdata", 64'(srdata), 0);
        chk("rs_stall", 64'(stall), 0);
        dok = 1; rd = 32'hCAFEF00D;
        step();
        dok = 0;
        #1;
        chk("rs_late_state", 64'(u32.state), 0);
        chk("rs_late_rdata", 64'(srdata), 0);
        en = 1; saddr = 32'h00000300; wen = 4'b0100;
        step();
        chk("rs_new_req", 64'(req), 1);
        chk("rs_new_addr", 64'(oaddr), 64'h300);
        chk("rs_byte_size", 64'(size), 0);
        chk("rs_byte_wr", 64'(wr), 1);

        // 64-bit channels
        en64 = 1; wen64 = 8'hFF;
        step();
        chk("d64_ff_size", 64'(a_size), 3);
        chk("d64_ff_wr", 64'(a_wr), 1);
        chk("ro_wr", 64'(b_wr), 0);
        chk("ro_size", 64'(b_size), 3);
        rst = 1;
        step();
        rst = 0; wen64 = 8'h0F;
        step();
        chk("d64_0f_size", 64'(a_size), 2);
        chk("d64_0f_wr", 64'(a_wr), 1);
        rst = 1;
        step();
        rst = 0; wen64 = 8'h13;
        step();
        chk("d64_odd_size", 64'(a_size), 3);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
